// File: rtl/axis_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : axis_skid_reg
// Description : Two-entry AXI-Stream register slice. The downstream side is
//               driven only from the output register; a bypass register
//               absorbs the beat that arrives while the output is stalled.
//               Upstream ready is simply "bypass register empty".
// Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_tdata_i,
  input  logic [KEEP_WIDTH-1:0] in_tkeep_i,
  input  logic                  in_tvalid_i,
  output logic                  in_tready_o,
  input  logic                  in_tlast_i,
  input  logic [USER_WIDTH-1:0] in_tuser_i,
  output logic [DATA_WIDTH-1:0] out_tdata_o,
  output logic [KEEP_WIDTH-1:0] out_tkeep_o,
  output logic                  out_tvalid_o,
  input  logic                  out_tready_i,
  output logic                  out_tlast_o,
  output logic [USER_WIDTH-1:0] out_tuser_o
);

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [KEEP_WIDTH-1:0] out_keep_q;
  logic                  out_last_q;
  logic [USER_WIDTH-1:0] out_user_q;

  logic                  byp_valid_q;
  logic [DATA_WIDTH-1:0] byp_data_q;
  logic [KEEP_WIDTH-1:0] byp_keep_q;
  logic                  byp_last_q;
  logic [USER_WIDTH-1:0] byp_user_q;

  logic w_in_fire;
  logic w_out_free;

  assign in_tready_o = !byp_valid_q;
  assign w_in_fire   = in_tvalid_i && !byp_valid_q;
  // Output register can take a new beat when empty or being drained this cycle.
  assign w_out_free  = !out_valid_q || out_tready_i;

  assign out_tdata_o  = out_data_q;
  assign out_tkeep_o  = out_keep_q;
  assign out_tvalid_o = out_valid_q;
  assign out_tlast_o  = out_last_q;
  assign out_tuser_o  = out_user_q;

  // Refill the output register from the bypass first, else from the input;
  // park an input beat in the bypass while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= '0;
      byp_valid_q <= 1'b0;
      byp_data_q  <= '0;
      byp_keep_q  <= '0;
      byp_last_q  <= 1'b0;
      byp_user_q  <= '0;
    end else begin
      if (w_out_free) begin
        if (byp_valid_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= byp_data_q;
          out_keep_q  <= byp_keep_q;
          out_last_q  <= byp_last_q;
          out_user_q  <= byp_user_q;
          byp_valid_q <= 1'b0;
        end else begin
          out_valid_q <= w_in_fire;
          if (w_in_fire) begin
            out_data_q <= in_tdata_i;
            out_keep_q <= in_tkeep_i;
            out_last_q <= in_tlast_i;
            out_user_q <= in_tuser_i;
          end
        end
      end else if (w_in_fire) begin
        byp_valid_q <= 1'b1;
        byp_data_q  <= in_tdata_i;
        byp_keep_q  <= in_tkeep_i;
        byp_last_q  <= in_tlast_i;
        byp_user_q  <= in_tuser_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_pred_mux.sv
`default_nettype none
// ============================================================================
// Module      : axis_pred_mux
// Description : Frame-granular AXI-Stream multiplexer driven by an external
//               predictive round-robin arbiter. Locks onto the granted port
//               for a whole frame, forwards it through a skid register and
//               pulses acknowledge on the accepted tlast beat.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pred_mux #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic [S_COUNT-1:0]               s_axis_tvalid,
  output logic [S_COUNT-1:0]               s_axis_tready,
  input  logic [S_COUNT-1:0]               s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic [S_COUNT-1:0]               request,
  output logic [S_COUNT-1:0]               acknowledge,
  input  logic [S_COUNT-1:0]               grant,
  input  logic                             grant_valid,
  input  logic [$clog2(S_COUNT)-1:0]       grant_encoded,
  output logic                             frame_active,
  output logic [31:0]                      stat_frames
);

  localparam int SEL_W = $clog2(S_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic              frame_active_q;
  logic [31:0]       stat_frames_q;

  logic [DATA_WIDTH-1:0] w_sel_tdata;
  logic [KEEP_WIDTH-1:0] w_sel_tkeep;
  logic                  w_sel_tvalid;
  logic                  w_sel_tlast;
  logic [USER_WIDTH-1:0] w_sel_tuser;
  logic                  w_in_valid;
  logic                  w_skid_ready;
  logic                  w_last_accept;

  assign request      = s_axis_tvalid;
  assign frame_active = frame_active_q;
  assign stat_frames  = stat_frames_q;

  // Pick the locked port's beat off the packed input buses.
  always_comb begin
    w_sel_tdata  = '0;
    w_sel_tkeep  = '0;
    w_sel_tvalid = 1'b0;
    w_sel_tlast  = 1'b0;
    w_sel_tuser  = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (sel_q == SEL_W'(i)) begin
        w_sel_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_tkeep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        w_sel_tvalid = s_axis_tvalid[i];
        w_sel_tlast  = s_axis_tlast[i];
        w_sel_tuser  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  assign w_in_valid    = (state_q == ST_ACTIVE) && w_sel_tvalid;
  assign w_last_accept = w_in_valid && w_skid_ready && w_sel_tlast;

  // Only the locked port sees ready, and only while ACTIVE; the frame-ending
  // accept is reported back to the arbiter in the same cycle.
  always_comb begin
    s_axis_tready = '0;
    acknowledge   = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if ((state_q == ST_ACTIVE) && (sel_q == SEL_W'(i))) begin
        s_axis_tready[i] = w_skid_ready;
        acknowledge[i]   = w_last_accept;
      end
    end
  end

  // Frame lock FSM: wait for a live grant, forward one frame, then give the
  // arbiter one quiet cycle to register its post-acknowledge decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      sel_q          <= '0;
      frame_active_q <= 1'b0;
      stat_frames_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid && ((grant & s_axis_tvalid) != '0)) begin
            sel_q          <= grant_encoded;
            state_q        <= ST_ACTIVE;
            frame_active_q <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (w_last_accept) begin
            stat_frames_q  <= stat_frames_q + 32'd1;
            state_q        <= ST_HOLD;
            frame_active_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          state_q        <= ST_IDLE;
          frame_active_q <= 1'b0;
        end
        default: begin
          state_q        <= ST_IDLE;
          frame_active_q <= 1'b0;
        end
      endcase
    end
  end

  axis_skid_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .USER_WIDTH (USER_WIDTH)
  ) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_tdata_i   (w_sel_tdata),
    .in_tkeep_i   (w_sel_tkeep),
    .in_tvalid_i  (w_in_valid),
    .in_tready_o  (w_skid_ready),
    .in_tlast_i   (w_sel_tlast),
    .in_tuser_i   (w_sel_tuser),
    .out_tdata_o  (m_axis_tdata),
    .out_tkeep_o  (m_axis_tkeep),
    .out_tvalid_o (m_axis_tvalid),
    .out_tready_i (m_axis_tready),
    .out_tlast_o  (m_axis_tlast),
    .out_tuser_o  (m_axis_tuser)
  );

endmodule
`default_nettype wire

// File: tb/tb_axis_pred_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_pred_mux
// Description : Self-checking bench for axis_pred_mux with a round-robin
//               arbiter model, per-port frame sources and a per-port
//               in-order scoreboard on the merged output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pred_mux;

  localparam int S  = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [S*DW-1:0]   s_axis_tdata = '0;
  logic [S*KW-1:0]   s_axis_tkeep = '0;
  logic [S-1:0]      s_axis_tvalid = '0;
  logic [S-1:0]      s_axis_tready;
  logic [S-1:0]      s_axis_tlast = '0;
  logic [S*UW-1:0]   s_axis_tuser = '0;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic [UW-1:0]     m_axis_tuser;
  logic [S-1:0]      request;
  logic [S-1:0]      acknowledge;
  logic [S-1:0]      grant = '0;
  logic              grant_valid = 1'b0;
  logic [1:0]        grant_encoded = '0;
  logic              frame_active;
  logic [31:0]       stat_frames;

  axis_pred_mux #(
    .S_COUNT    (S),
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .USER_WIDTH (UW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .request       (request),
    .acknowledge   (acknowledge),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_encoded (grant_encoded),
    .frame_active  (frame_active),
    .stat_frames   (stat_frames)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     seq = 0;
  beat_t  src_q [S][$];
  beat_t  exp_q [S][$];
  logic [S-1:0] en = '1;
  int     mtr_mode = 0;
  bit     pat [$];
  bit     rand_mode = 0;
  int     rr = 0;
  int     frames_model = 0;
  bit     in_frame = 0;
  int     cur_port = 0;
  bit     prev_stall = 0;
  logic [DW+KW+UW+1:0] prev_m = '0;
  int     first_m, last_m, m_beats, m_tlasts, stall_seen;
  int     first_acc [S];
  int     last_tl [S];
  int     ack_cnt [S];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    first_m = -1; last_m = -1; m_beats = 0; m_tlasts = 0; stall_seen = 0;
    for (int p = 0; p < S; p++) begin
      first_acc[p] = -1; last_tl[p] = -1; ack_cnt[p] = 0;
    end
  endtask

  task automatic drive_inputs();
    beat_t b;
    for (int p = 0; p < S; p++) begin
      if (src_q[p].size() > 0) begin
        b = src_q[p][0];
        s_axis_tvalid[p] = en[p];
      end else begin
        b = '0;
        s_axis_tvalid[p] = 1'b0;
      end
      s_axis_tdata[p*DW +: DW] = b.data;
      s_axis_tkeep[p*KW +: KW] = b.keep;
      s_axis_tlast[p]          = b.last;
      s_axis_tuser[p*UW +: UW] = b.user;
    end
  endtask

  task automatic add_frame(input int p, input int len);
    beat_t b;
    logic [7:0]  p8;
    logic [23:0] s24;
    for (int i = 0; i < len; i++) begin
      p8  = 8'(p);
      s24 = 24'(seq);
      b.data = {p8, s24, 32'($urandom())};
      b.keep = 8'($urandom());
      b.last = (i == len - 1);
      b.user = 1'($urandom());
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
      seq++;
    end
    drive_inputs();
  endtask

  function automatic bit busy();
    bit r = 0;
    for (int p = 0; p < S; p++)
      if (src_q[p].size() > 0 || exp_q[p].size() > 0) r = 1;
    return r;
  endfunction

  // One clock cycle: sample and check at the falling edge, then update the
  // arbiter model and source drivers just after the rising edge.
  task automatic tick();
    logic [S-1:0] fire, exp_ack, req_s;
    beat_t mb, e;
    int port, base, idx;
    bit got;
    @(negedge clk);
    fire    = s_axis_tvalid & s_axis_tready;
    exp_ack = fire & s_axis_tlast;
    req_s   = s_axis_tvalid;
    chk("acknowledge", acknowledge, exp_ack);
    chk("stat_frames", stat_frames, frames_model);
    chk("one_ready", ($countones(s_axis_tready) <= 1), 1);
    chk("request", request, s_axis_tvalid);
    if (prev_stall)
      chk("stall_stable", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, prev_m);
    if (m_axis_tvalid && m_axis_tready) begin
      mb.data = m_axis_tdata; mb.keep = m_axis_tkeep;
      mb.last = m_axis_tlast; mb.user = m_axis_tuser;
      port = int'(m_axis_tdata[DW-1:DW-8]);
      if (first_m < 0) first_m = cyc;
      last_m = cyc;
      m_beats++;
      if (m_axis_tlast) m_tlasts++;
      chk("out_port_range", (port < S), 1);
      if (port < S) begin
        if (in_frame) chk("unmixed", port, cur_port);
        chk("beat_expected", (exp_q[port].size() > 0), 1);
        if (exp_q[port].size() > 0) begin
          e = exp_q[port].pop_front();
          chk("out_beat", mb, e);
        end
      end
      in_frame = !m_axis_tlast;
      cur_port = port;
    end
    for (int p = 0; p < S; p++) begin
      if (fire[p]) begin
        if (first_acc[p] < 0) first_acc[p] = cyc;
        if (s_axis_tlast[p]) begin
          last_tl[p] = cyc;
          ack_cnt[p]++;
          frames_model++;
        end
      end
    end
    if (m_axis_tvalid && !m_axis_tready) stall_seen++;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_m = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};

    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < S; p++)
      if (fire[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    // Round-robin arbiter model: lowest index first out of reset, priority
    // moves past a port once its frame is acknowledged.
    if (!rst_n) begin
      rr = 0; grant = '0; grant_valid = 1'b0; grant_encoded = '0;
    end else begin
      base = rr;
      for (int p = 0; p < S; p++)
        if (exp_ack[p]) begin base = (p + 1) % S; rr = base; end
      got = 0; grant = '0;
      for (int k = 0; k < S; k++) begin
        idx = (base + k) % S;
        if (req_s[idx] && !got) begin
          got = 1; grant[idx] = 1'b1; grant_encoded = 2'(idx);
        end
      end
      grant_valid = got;
    end
    if (rand_mode)
      for (int p = 0; p < S; p++) en[p] = ($urandom_range(0, 3) != 0);
    case (mtr_mode)
      1:       m_axis_tready = ($urandom_range(0, 3) != 0);
      2:       m_axis_tready = (pat.size() > 0) ? pat.pop_front() : 1'b1;
      default: m_axis_tready = 1'b1;
    endcase
    drive_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int t0, f0, n;
    clear_stats();
    // ---- reset state ----
    run(3);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_frame_active", frame_active, 0);
    chk("rst_stat", stat_frames, 0);
    rst_n = 1'b1;
    run(2);

    // ---- single source, leading latency ----
    clear_stats();
    add_frame(2, 4);
    t0 = cyc;
    run(2);
    chk("ss_active_t2", frame_active, 1);
    chk("ss_tready_t2", s_axis_tready, 4'b0100);
    run(10);
    chk("ss_first_out", first_m, t0 + 3);
    chk("ss_last_out", last_m, t0 + 6);
    chk("ss_beats", m_beats, 4);
    chk("ss_ack_cnt", ack_cnt[2], 1);
    chk("ss_stat", stat_frames, 1);

    // ---- reset mid-frame ----
    clear_stats();
    add_frame(1, 5);
    n = 0;
    while (src_q[1].size() > 3 && n < 50) begin tick(); n++; end
    chk("mr_two_accepted", src_q[1].size(), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_m_tvalid", m_axis_tvalid, 0);
    chk("mr_m_fields", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 0);
    chk("mr_tready", s_axis_tready, 0);
    chk("mr_ack", acknowledge, 0);
    chk("mr_frame_active", frame_active, 0);
    chk("mr_stat", stat_frames, 0);
    for (int p = 0; p < S; p++) begin src_q[p].delete(); exp_q[p].delete(); end
    in_frame = 0; prev_stall = 0; frames_model = 0;
    drive_inputs();
    run(2);
    rst_n = 1'b1;
    clear_stats();
    run(10);
    chk("mr_no_tlast", m_tlasts, 0);
    chk("mr_stat_after", stat_frames, 0);

    // ---- contention between ports 0 and 3 ----
    clear_stats();
    add_frame(0, 3);
    add_frame(3, 3);
    run(16);
    chk("ct_order", (first_acc[0] < first_acc[3]), 1);
    chk("ct_gap", first_acc[3] - last_tl[0], 3);
    chk("ct_beats", m_beats, 6);
    chk("ct_drained", busy(), 0);

    // ---- backpressure during an 8-beat frame ----
    clear_stats();
    add_frame(0, 8);
    run(3);
    pat = '{1, 0, 0, 1, 0, 0, 1};
    mtr_mode = 2;
    run(25);
    mtr_mode = 0;
    chk("bp_beats", m_beats, 8);
    chk("bp_stalled", (stall_seen > 0), 1);
    chk("bp_drained", exp_q[0].size(), 0);

    // ---- prediction path: back-to-back single-beat frames on port 1 ----
    clear_stats();
    f0 = frames_model;
    for (int i = 0; i < 6; i++) add_frame(1, 1);
    run(30);
    chk("pp_acks", ack_cnt[1], 6);
    chk("pp_stat", stat_frames, f0 + 6);
    chk("pp_spacing", last_tl[1] - first_acc[1], 15);
    chk("pp_drained", busy(), 0);

    // ---- stale grant ----
    clear_stats();
    add_frame(2, 1);
    tick();
    void'(src_q[2].pop_front());
    void'(exp_q[2].pop_front());
    drive_inputs();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sg_frame_active", frame_active, 0);
      chk("sg_tready", s_axis_tready, 0);
    end
    chk("sg_ack", ack_cnt[2], 0);
    chk("sg_no_out", m_beats, 0);

    // ---- randomized traffic ----
    clear_stats();
    rand_mode = 1;
    mtr_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(0, S - 1);
        if (src_q[n].size() < 12) add_frame(n, $urandom_range(1, 6));
      end
      tick();
    end
    rand_mode = 0;
    mtr_mode = 0;
    en = '1;
    drive_inputs();
    n = 0;
    while (busy() && n < 3000) begin tick(); n++; end
    chk("rnd_drained", busy(), 0);
    run(4);
    chk("rnd_idle_out", m_axis_tvalid, 0);
    chk("rnd_frame_closed", in_frame, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_pred_mux.md
# axis_pred_mux

Frame-granular AXI-Stream multiplexer that sits directly downstream of the predictive round-robin arbiter in the l3fwd datapath.
- Presents per-port `request` to the arbiter, consumes its `grant`, `grant_valid` and `grant_encoded`.
- Locks onto the granted port for one full frame and forwards it through a skid-buffered output register.
- Pulses `acknowledge` on the accepted `tlast` beat, so the arbiter can re-arbitrate or keep its prediction.

## Interface
- `S_COUNT`, 4, number of input streams (≥2)
- `DATA_WIDTH`, 64, tdata width
- `KEEP_WIDTH`, `DATA_WIDTH/8`, tkeep width
- `USER_WIDTH`, 1, tuser width
- `clk`  in  1  sole clock, all logic rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `s_axis_tdata/tkeep/tvalid/tready/tlast/tuser`  in/out  `S_COUNT`×field  packed input streams (tready is output)
- `m_axis_tdata/tkeep/tvalid/tready/tlast/tuser`  out/in  field  merged output stream
- `request`  out  `S_COUNT`  to arbiter
- `acknowledge`  out  `S_COUNT`  to arbiter
- `grant`  in  `S_COUNT`  from arbiter
- `grant_valid`  in  1  from arbiter
- `grant_encoded`  in  `$clog2(S_COUNT)`  from arbiter
- `frame_active`  out  1  status, high while in ACTIVE
- `stat_frames`  out  32  forwarded-frame counter, wraps at 2^32

## Operation
Arbiter handshake:
- `request[i] = s_axis_tvalid[i]`.
- `acknowledge[i]` is a one-cycle pulse, combinational, in the cycle where the `tlast` beat of port i is accepted (tvalid & tready & tlast).

FSM states:
- **IDLE**: all `s_axis_tready` low.
  - If `grant_valid` and `(grant & s_axis_tvalid) != 0`: load `sel <= grant_encoded` and go to ACTIVE.
  - Otherwise stay in IDLE. A stale grant whose port has deasserted tvalid is ignored.
- **ACTIVE**:
  - `s_axis_tready[sel] = skid_ready`; all other readies are low.
  - Accepted beats are written into the skid stage unchanged.
  - An accepted `tlast` beat pulses `acknowledge[sel]`, increments `stat_frames`, and goes to HOLD.
- **HOLD**: exactly one cycle, all readies low. This lets the arbiter register its post-ack decision. It always goes to IDLE.

Output skid stage:
- Two entries: output register plus one bypass register.
- `skid_ready` = bypass register empty.
- `m_axis_*` is driven only from the output register and is never combinational from inputs.
- With `m_axis_tready` held high, throughput is one beat per cycle.

## Timing
- Reset values: `m_axis_tvalid` 0, `m_axis_tdata/tkeep/tlast/tuser` 0, `s_axis_tready` 0, `acknowledge` 0, `frame_active` 0, `stat_frames` 0, FSM IDLE, `sel` 0, skid empty.
- Reset assertion clears these immediately, including mid-frame. A partial frame is dropped; no `tlast` is fabricated.
- Leading latency, with an idle arbiter:
  - tvalid rises at cycle t.
  - Grant is registered at t+1.
  - ACTIVE and tready are high at t+2.
  - First beat appears on `m_axis_tvalid` at t+3.
- Frame-to-frame gap from `tlast` accept: HOLD (+1), then IDLE sees the new grant (+2), then ACTIVE (+3). That is two idle input cycles per frame boundary.
- Single-beat frame (`tlast` on first beat) goes ACTIVE→HOLD after one cycle.
- `m_axis_tready` low: the skid absorbs at most one extra beat. `skid_ready` drops the cycle after the bypass register fills.
- `m_axis_*` is held stable while `m_axis_tvalid & !m_axis_tready`.
- Unselected port deasserting tvalid while another frame is in ACTIVE: no effect.
- Selected port deasserting tvalid mid-frame: stay in ACTIVE, no timeout.
- Simultaneous `tlast` accept and `m_axis_tready` low: the beat goes into the bypass register and HOLD proceeds normally.

## Structure
- No shared package. FSM encoding is local (2-bit: IDLE=0, ACTIVE=1, HOLD=2); code 3 returns to IDLE.
- One sub-module: `axis_skid_reg` (parameters DATA/KEEP/USER widths, ports `clk`/`rst_n`). It is reusable by other l3fwd stages.
- Input selection is a `sel`-indexed mux over the packed buses.

## Test plan
- Reset mid-frame: port 1 sends a 5-beat frame, `rst_n` drops after beat 2 → all outputs 0 the same cycle; after release `stat_frames`=0 and no `tlast` is emitted.
- Single source: port 2 sends a 4-beat frame, arbiter grants 2 at t+1 → output beats at t+3..t+6, `acknowledge`=4'b0100 for one cycle on the 4th accept, `stat_frames`=1.
- Contention: ports 0 and 3 each send 3-beat frames simultaneously (round-robin arbiter, LSB high) → frames are output unmixed (port 0 first, then port 3), two idle input cycles between them.
- Backpressure: `m_axis_tready` toggles 1,0,0,1 during an 8-beat frame → all 8 beats arrive in order, no duplicates, data stable while stalled.
- Prediction path: port 1 sends back-to-back 1-beat frames continuously → every frame is acknowledged, `grant_encoded` stays 1, `stat_frames` increments once per frame.
- Stale grant: granted port withdraws tvalid before IDLE sees the grant → stay in IDLE, no tready asserted, no ack.
